// File: rtl/fsk_burst_sequencer_pkg.sv
// Shared FSK transmit types and default carrier timing used by the sequencer and system_top.
// Pure definitions: no latency, no flow control.
package fsk_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      PHASE_A,
      DEAD_AB,
      PHASE_B,
      DEAD_BA,
      WAIT_DONE
   } state_t;

   localparam int HALF_1_DEF = 20;
   localparam int HALF_0_DEF = 25;
   localparam int DEAD_T_DEF = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fsk_burst_sequencer_if.sv
// Command/status and H-bridge gate bundle between SPI-side logic and the burst sequencer.
// Wires only: no latency; start is a pulse sampled in IDLE, no backpressure.
interface fsk_burst_sequencer_if #(parameter int DATA_W = 8);
   logic              i_Start;
   logic [DATA_W-1:0] i_Data;
   logic              i_Done_Trig;
   logic              o_Busy;
   logic              o_Master_Trig;
   logic              F1Q1;
   logic              F1Q4;
   logic              F2Q2;
   logic              F2Q3;
   logic              o_Done;
   logic              o_Timeout;

   modport master (
      output i_Start, i_Data, i_Done_Trig,
      input  o_Busy, o_Master_Trig, F1Q1, F1Q4, F2Q2, F2Q3, o_Done, o_Timeout
   );

   modport slave (
      input  i_Start, i_Data, i_Done_Trig,
      output o_Busy, o_Master_Trig, F1Q1, F1Q4, F2Q2, F2Q3, o_Done, o_Timeout
   );
endinterface

// File: rtl/fsk_burst_sequencer_phase_timer.sv
// Loadable down-counter; tc is high while the count is zero, so a load of N-1 spans N cycles.
// Load takes effect at the next edge; no backpressure.
module fsk_phase_timer #(
   parameter int W = 5
) (
   input  logic         i_fpga_clock,
   input  logic         i_Rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge i_fpga_clock) begin
      if (i_Rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/fsk_burst_sequencer.sv
// One FSK burst onto the H-bridge diagonals, MSB-first, with dead time; all outputs registered.
// Start sampled only in IDLE (no queueing); done waits for i_Done_Trig or DONE_TMO clocks.
module fsk_burst_sequencer
   import fsk_tx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int HALF_1      = HALF_1_DEF,
   parameter int HALF_0      = HALF_0_DEF,
   parameter int DEAD_T      = DEAD_T_DEF,
   parameter int CYC_PER_BIT = 4,
   parameter int DONE_TMO    = 1000
) (
   input logic                  i_fpga_clock,
   input logic                  i_Rst,
   fsk_burst_sequencer_if.slave bus
);

   localparam int TW  = $clog2(max2(HALF_0, HALF_1));
   localparam int BW  = max2(2, $clog2(DATA_W + 1));
   localparam int PW  = max2(2, $clog2(CYC_PER_BIT + 1));
   localparam int TMW = max2(2, $clog2(DONE_TMO + 1));

   state_t            state, state_nxt;
   logic [DATA_W-1:0] sr, sr_nxt;
   logic [BW-1:0]     bits, bits_nxt;
   logic [PW-1:0]     per_cnt, per_nxt;
   logic [TMW-1:0]    tmo_cnt, tmo_nxt;
   logic              tm_load, tm_tc;
   logic [TW-1:0]     tm_val;
   logic              done_hit, tmo_hit;
   int                half;

   logic gate_a, gate_b, trig, busy, done, timeout;
   logic gate_a_nxt, gate_b_nxt, trig_nxt, busy_nxt, done_nxt, timeout_nxt;

   fsk_phase_timer #(.W(TW)) u_timer (
      .i_fpga_clock (i_fpga_clock),
      .i_Rst        (i_Rst),
      .load         (tm_load),
      .load_val     (tm_val),
      .tc           (tm_tc)
   );

   always_ff @(posedge i_fpga_clock) begin
      if (i_Rst) begin
         state   <= IDLE;
         sr      <= '0;
         bits    <= '0;
         per_cnt <= '0;
         tmo_cnt <= '0;
         gate_a  <= 1'b0;
         gate_b  <= 1'b0;
         trig    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         sr      <= sr_nxt;
         bits    <= bits_nxt;
         per_cnt <= per_nxt;
         tmo_cnt <= tmo_nxt;
         gate_a  <= gate_a_nxt;
         gate_b  <= gate_b_nxt;
         trig    <= trig_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      bits_nxt  = bits;
      per_nxt   = per_cnt;
      tmo_nxt   = tmo_cnt;
      done_hit  = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_Start) begin
               state_nxt = TRIG;
               sr_nxt    = bus.i_Data;
               bits_nxt  = BW'(DATA_W);
               per_nxt   = '0;
            end
         end
         TRIG:    state_nxt = PHASE_A;
         PHASE_A: if (tm_tc) state_nxt = DEAD_AB;
         DEAD_AB: if (tm_tc) state_nxt = PHASE_B;
         PHASE_B: if (tm_tc) state_nxt = DEAD_BA;
         DEAD_BA: begin
            // Bit changes only here, so every carrier period stays symmetric.
            if (tm_tc) begin
               if (per_cnt == PW'(CYC_PER_BIT - 1)) begin
                  per_nxt   = '0;
                  sr_nxt    = sr << 1;
                  bits_nxt  = bits - BW'(1);
                  tmo_nxt   = '0;
                  state_nxt = (bits == BW'(1)) ? WAIT_DONE : PHASE_A;
               end else begin
                  per_nxt   = per_cnt + PW'(1);
                  state_nxt = PHASE_A;
               end
            end
         end
         WAIT_DONE: begin
            if (bus.i_Done_Trig) begin
               done_hit  = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMW'(DONE_TMO - 1)) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo_cnt + TMW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Interval length uses the bit that will be current after this edge.
      half    = sr_nxt[DATA_W-1] ? HALF_1 : HALF_0;
      tm_load = (state_nxt != state);
      if (state_nxt == PHASE_A || state_nxt == PHASE_B) begin
         tm_val = TW'(half - DEAD_T - 1);
      end else begin
         tm_val = TW'(DEAD_T - 1);
      end
   end

   always_comb begin
      gate_a_nxt  = (state_nxt == PHASE_A);
      gate_b_nxt  = (state_nxt == PHASE_B);
      trig_nxt    = (state_nxt == TRIG);
      busy_nxt    = (state_nxt != IDLE);
      done_nxt    = done_hit | tmo_hit;
      timeout_nxt = tmo_hit;
   end

   assign bus.F1Q1          = gate_a;
   assign bus.F1Q4          = gate_a;
   assign bus.F2Q2          = gate_b;
   assign bus.F2Q3          = gate_b;
   assign bus.o_Master_Trig = trig;
   assign bus.o_Busy        = busy;
   assign bus.o_Done        = done;
   assign bus.o_Timeout     = timeout;

endmodule

// File: tb/tb_fsk_burst_sequencer.sv
// Scoreboard bench: stimulus queues expected output events (cycle-stamped), a negedge monitor pops and compares.
module tb_fsk_burst_sequencer;
   import fsk_tx_pkg::*;

   localparam int KT = 0;
   localparam int KD = 1;
   localparam int KB = 2;
   localparam int KG = 3;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic i_fpga_clock = 1'b0;
   logic i_Rst        = 1'b1;

   fsk_burst_sequencer_if #(.DATA_W(8)) bus ();

   fsk_burst_sequencer #(
      .DATA_W      (8),
      .HALF_1      (20),
      .HALF_0      (25),
      .DEAD_T      (2),
      .CYC_PER_BIT (4),
      .DONE_TMO    (1000)
   ) dut (
      .i_fpga_clock (i_fpga_clock),
      .i_Rst        (i_Rst),
      .bus          (bus)
   );

   always #5 i_fpga_clock = ~i_fpga_clock;

   int   cyc = 0;
   always @(posedge i_fpga_clock) cyc <= cyc + 1;

   ev_t  q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   function automatic string kname(input int k);
      case (k)
         KT:      return "master_trig";
         KD:      return "done_timeout";
         KB:      return "busy";
         default: return "gate_edge";
      endcase
   endfunction

   task automatic observe(input int kind, input int val);
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got val=%0d at cyc=%0d, required no event", kname(kind), val, cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            n_bad++;
            $display("FAIL %s: got %s val=%0d cyc=%0d, required %s val=%0d cyc=%0d",
                     kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
         end
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   initial begin
      logic [1:0] pg;
      logic       pb;
      logic [1:0] g;
      pg = 2'b00;
      pb = 1'b0;
      forever begin
         @(negedge i_fpga_clock);
         if (mon_en) begin
            n_cmp++;
            if (((bus.F1Q1 | bus.F1Q4) & (bus.F2Q2 | bus.F2Q3)) || bus.F1Q1 !== bus.F1Q4 || bus.F2Q2 !== bus.F2Q3) begin
               n_bad++;
               $display("FAIL gate_invariant: got F1Q1=%b F1Q4=%b F2Q2=%b F2Q3=%b at cyc=%0d, required no overlap and equal pairs",
                        bus.F1Q1, bus.F1Q4, bus.F2Q2, bus.F2Q3, cyc);
            end
            if (bus.o_Master_Trig) observe(KT, 1);
            if (bus.o_Done || bus.o_Timeout) observe(KD, int'({bus.o_Done, bus.o_Timeout}));
            if (bus.o_Busy != pb) observe(KB, int'(bus.o_Busy));
            pb = bus.o_Busy;
            g  = {bus.F1Q1, bus.F2Q2};
            if (g != pg) observe(KG, int'(g));
            pg = g;
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge i_fpga_clock);
   endtask

   // Called at a negedge; start is sampled at the next edge. Returns WAIT_DONE entry cycle.
   task automatic start_burst(input logic [7:0] d, output int t_end);
      int c, t, h;
      c = cyc;
      bus.i_Start = 1'b1;
      bus.i_Data  = d;
      q.push_back('{KT, c + 1, 1});
      q.push_back('{KB, c + 1, 1});
      t = c + 2;
      q.push_back('{KG, t, 2});
      for (int i = 7; i >= 0; i--) begin
         h = d[i] ? 20 : 25;
         for (int p = 0; p < 4; p++) begin
            q.push_back('{KG, t + h - 2, 0});
            q.push_back('{KG, t + h, 1});
            q.push_back('{KG, t + 2 * h - 2, 0});
            t = t + 2 * h;
            if (!(i == 0 && p == 3)) q.push_back('{KG, t, 2});
         end
      end
      t_end = t;
      @(negedge i_fpga_clock);
      bus.i_Start = 1'b0;
   endtask

   task automatic expect_done(input int at, input int val);
      q.push_back('{KD, at, val});
      q.push_back('{KB, at, 0});
   endtask

   task automatic pulse_done_trig;
      bus.i_Done_Trig = 1'b1;
      @(negedge i_fpga_clock);
      bus.i_Done_Trig = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, bus.o_Busy, 1'b0);
      chk({tag, "_trig"}, bus.o_Master_Trig, 1'b0);
      chk({tag, "_f1q1"}, bus.F1Q1, 1'b0);
      chk({tag, "_f1q4"}, bus.F1Q4, 1'b0);
      chk({tag, "_f2q2"}, bus.F2Q2, 1'b0);
      chk({tag, "_f2q3"}, bus.F2Q3, 1'b0);
      chk({tag, "_done"}, bus.o_Done, 1'b0);
      chk({tag, "_timeout"}, bus.o_Timeout, 1'b0);
   endtask

   initial begin
      int   te, c, r;
      ev_t  keep[$];
      bus.i_Start     = 1'b0;
      bus.i_Data      = 8'h00;
      bus.i_Done_Trig = 1'b0;
      repeat (3) @(negedge i_fpga_clock);
      i_Rst = 1'b0;
      check_all_zero("reset");
      mon_en = 1'b1;
      @(negedge i_fpga_clock);

      // A5: acknowledged 10 clocks into WAIT_DONE
      start_burst(8'hA5, te);
      wait_until(te + 10);
      expect_done(te + 11, 2);
      pulse_done_trig();
      wait_until(te + 13);

      // 3C: no acknowledge, timeout after 1000 WAIT_DONE cycles
      start_burst(8'h3C, te);
      expect_done(te + 1000, 3);
      wait_until(te + 1003);

      // C3: mid-burst start/ack ignored, ack coincides with terminal count
      c = cyc;
      start_burst(8'hC3, te);
      wait_until(c + 102);
      bus.i_Start     = 1'b1;
      bus.i_Data      = 8'h00;
      bus.i_Done_Trig = 1'b1;
      @(negedge i_fpga_clock);
      bus.i_Start     = 1'b0;
      bus.i_Done_Trig = 1'b0;
      wait_until(te + 999);
      expect_done(te + 1000, 2);
      pulse_done_trig();
      wait_until(te + 1003);

      // FF: reset while in PHASE_B of the first period
      c = cyc;
      start_burst(8'hFF, te);
      r = c + 2 + 25;
      wait_until(r);
      i_Rst = 1'b1;
      keep.delete();
      foreach (q[i]) if (q[i].cyc <= r) keep.push_back(q[i]);
      q = keep;
      q.push_back('{KB, r + 1, 0});
      q.push_back('{KG, r + 1, 0});
      @(negedge i_fpga_clock);
      i_Rst = 1'b0;
      check_all_zero("midrst");
      repeat (2) @(negedge i_fpga_clock);

      // 5A: full burst after reset
      start_burst(8'h5A, te);
      wait_until(te + 10);
      expect_done(te + 11, 2);
      pulse_done_trig();
      wait_until(te + 15);

      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_events: got %0d outstanding (first kind=%0d cyc=%0d), required 0",
                  q.size(), q[0].kind, q[0].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: got no completion by cyc=%0d, required finish", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
